// File: rtl/bin_tape_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bin_tape_loader
// Purpose  : Receiver for PAL BIN paper-tape images. Decodes leader, origin,
//            data, checksum and trailer frames from a byte stream and writes
//            the decoded 12-bit words to memory over a write_enable /
//            mem_finished handshake. Used while the CPU is halted.
// Ports    : clk              - system clock, all flops on posedge
//            btnCpuReset      - asynchronous active-low reset
//            start            - 1-cycle arm pulse (honoured in IDLE/DONE/ERROR)
//            byte_valid/data  - tape byte offered by the source
//            byte_ready       - loader accepts the offered byte this cycle
//            mem_write_enable - memory write request
//            mem_address      - write address (0 when no request)
//            mem_write_data   - write data    (0 when no request)
//            mem_finished     - memory has completed the current write
//            busy             - a load is in progress
//            done             - trailer seen, held until next start
//            checksum_ok      - tape checksum matched (meaningful with done)
//            error            - framing error, held until next start
//            word_count       - data words written since start
// Revision : 1.0 - initial release
// ============================================================================
module bin_tape_loader #(
  parameter logic [11:0] DEFAULT_ORIGIN = 12'o0200,
  parameter int          COUNT_WIDTH    = 13
) (
  input  logic                   clk,
  input  logic                   btnCpuReset,
  input  logic                   start,
  input  logic                   byte_valid,
  input  logic [7:0]             byte_data,
  output logic                   byte_ready,
  output logic                   mem_write_enable,
  output logic [11:0]            mem_address,
  output logic [11:0]            mem_write_data,
  input  logic                   mem_finished,
  output logic                   busy,
  output logic                   done,
  output logic                   checksum_ok,
  output logic                   error,
  output logic [COUNT_WIDTH-1:0] word_count
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_SEEK   = 4'd1,
    S_LEADER = 4'd2,
    S_HIGH   = 4'd3,
    S_LOW    = 4'd4,
    S_FRAME  = 4'd5,
    S_WRITE  = 4'd6,
    S_CHECK  = 4'd7,
    S_DONE   = 4'd8,
    S_ERROR  = 4'd9
  } state_t;

  state_t                 state, state_n;
  logic [7:0]             hi, hi_n;
  logic [7:0]             lo, lo_n;
  logic [11:0]            address, address_n;
  logic [11:0]            pending, pending_n;
  logic                   pending_valid, pending_valid_n;
  logic [11:0]            pend_sum, pend_sum_n;
  logic [11:0]            sum, sum_n;
  logic                   sum_ok, sum_ok_n;
  logic [COUNT_WIDTH-1:0] count, count_n;

  logic        take;
  logic        is_leader;
  logic        is_field;
  logic        is_frame;
  logic [11:0] value;

  assign is_leader = (byte_data == 8'o200);
  assign is_field  = (byte_data[7:6] == 2'b11);
  assign is_frame  = ~byte_data[7];
  assign value     = {hi[5:0], lo[5:0]};

  assign byte_ready = (state == S_SEEK) || (state == S_LEADER) ||
                      (state == S_HIGH) || (state == S_LOW);
  assign take       = byte_valid && byte_ready;

  // Request lines are gated so every output reads 0 outside a write,
  // including right after reset when address holds DEFAULT_ORIGIN.
  assign mem_write_enable = (state == S_WRITE);
  assign mem_address      = mem_write_enable ? address : 12'd0;
  assign mem_write_data   = mem_write_enable ? pending : 12'd0;
  assign busy             = !((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));
  assign done             = (state == S_DONE);
  assign error            = (state == S_ERROR);
  assign checksum_ok      = done && sum_ok;
  assign word_count       = count;

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state         <= S_IDLE;
      hi            <= 8'd0;
      lo            <= 8'd0;
      address       <= DEFAULT_ORIGIN;
      pending       <= 12'd0;
      pending_valid <= 1'b0;
      pend_sum      <= 12'd0;
      sum           <= 12'd0;
      sum_ok        <= 1'b0;
      count         <= '0;
    end else begin
      state         <= state_n;
      hi            <= hi_n;
      lo            <= lo_n;
      address       <= address_n;
      pending       <= pending_n;
      pending_valid <= pending_valid_n;
      pend_sum      <= pend_sum_n;
      sum           <= sum_n;
      sum_ok        <= sum_ok_n;
      count         <= count_n;
    end
  end

  always_comb begin
    state_n         = state;
    hi_n            = hi;
    lo_n            = lo;
    address_n       = address;
    pending_n       = pending;
    pending_valid_n = pending_valid;
    pend_sum_n      = pend_sum;
    sum_n           = sum;
    sum_ok_n        = sum_ok;
    count_n         = count;

    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_n         = S_SEEK;
          address_n       = DEFAULT_ORIGIN;
          pending_valid_n = 1'b0;
          sum_n           = 12'd0;
          sum_ok_n        = 1'b0;
          count_n         = '0;
        end
      end

      S_SEEK: begin
        if (take && is_leader) state_n = S_LEADER;
      end

      // Field bytes and the unused 0201-0277 codes are consumed without
      // any effect in the framing states.
      S_LEADER, S_HIGH: begin
        if (take) begin
          if (is_frame) begin
            hi_n    = byte_data;
            state_n = S_LOW;
          end else if (is_leader && (state == S_HIGH)) begin
            state_n = S_CHECK;
          end
        end
      end

      S_LOW: begin
        if (take) begin
          if (is_frame) begin
            lo_n    = byte_data;
            state_n = S_FRAME;
          end else if (is_leader) begin
            state_n = S_ERROR;
          end
        end
      end

      // hi/lo stay untouched across a write (no bytes are accepted), so
      // returning here after the commit processes the held frame.
      S_FRAME: begin
        if (pending_valid) begin
          state_n = S_WRITE;
        end else begin
          if (hi[6]) begin
            address_n = value;
          end else begin
            pending_n       = value;
            pending_valid_n = 1'b1;
            pend_sum_n      = sum;
          end
          sum_n   = sum + {4'd0, hi} + {4'd0, lo};
          state_n = S_HIGH;
        end
      end

      S_WRITE: begin
        if (mem_finished) begin
          address_n       = address + 12'd1;
          count_n         = count + COUNT_WIDTH'(1);
          pending_valid_n = 1'b0;
          state_n         = S_FRAME;
        end
      end

      // The word still pending at the trailer is the tape checksum.
      S_CHECK: begin
        sum_ok_n        = pending_valid && (pending == pend_sum);
        pending_valid_n = 1'b0;
        state_n         = S_DONE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_bin_tape_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bin_tape_loader
// Purpose  : Self-checking bench for bin_tape_loader. A tape-level reference
//            model predicts the memory writes and final status of each tape;
//            a monitor compares every write request against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_tape_loader;

  localparam int CW = 13;
  typedef logic [7:0] byte_t;
  typedef byte_t tape_t[$];

  logic          clk = 1'b0;
  logic          btnCpuReset = 1'b0;
  logic          start = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = 8'd0;
  logic          mem_finished = 1'b0;
  logic          byte_ready;
  logic          mem_write_enable;
  logic [11:0]   mem_address;
  logic [11:0]   mem_write_data;
  logic          busy, done, checksum_ok, error;
  logic [CW-1:0] word_count;

  always #5 clk = ~clk;

  bin_tape_loader #(.DEFAULT_ORIGIN(12'o0200), .COUNT_WIDTH(CW)) dut (
    .clk              (clk),
    .btnCpuReset      (btnCpuReset),
    .start            (start),
    .byte_valid       (byte_valid),
    .byte_data        (byte_data),
    .byte_ready       (byte_ready),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_finished     (mem_finished),
    .busy             (busy),
    .done             (done),
    .checksum_ok      (checksum_ok),
    .error            (error),
    .word_count       (word_count)
  );

  int vectors = 0;
  int miscompares = 0;

  // Expected results of the tape currently being loaded
  logic [23:0]   exp_q[$];
  logic [CW-1:0] exp_wc;
  logic          exp_done, exp_ck, exp_err;

  bit          mon_en = 1'b0;
  bit          in_req = 1'b0;
  logic [11:0] req_addr, req_data;
  int          mem_delay_fixed = -1;
  int          mem_delay_max = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0o, required %0o", name, act, req);
    end
  endtask

  task automatic fail_now(input string msg);
    vectors++;
    miscompares++;
    $display("FAIL %s", msg);
  endtask

  function automatic int pick_delay();
    if (mem_delay_fixed >= 0) return mem_delay_fixed;
    return int'($urandom_range(0, mem_delay_max));
  endfunction

  // Tape-level reference: parse the byte stream into frames, then replay them.
  task automatic model_tape(input tape_t t);
    logic [15:0] fr[$];
    bit          seen_leader, have_hi, by_trailer, by_error;
    byte_t       hb, b;
    logic [7:0]  h, l;
    logic [11:0] addr, sum, v;
    seen_leader = 0; have_hi = 0; by_trailer = 0; by_error = 0; hb = 8'd0;
    exp_q.delete();
    exp_wc = '0; exp_ck = 1'b0; exp_done = 1'b0; exp_err = 1'b0;
    for (int i = 0; i < t.size() && !by_trailer && !by_error; i++) begin
      b = t[i];
      if (!seen_leader) begin
        if (b == 8'o200) seen_leader = 1;
      end else if (b[7:6] == 2'b11) begin
        // field byte: no effect
      end else if (b == 8'o200) begin
        if (have_hi) by_error = 1;
        else if (fr.size() > 0) by_trailer = 1;
      end else if (!b[7]) begin
        if (!have_hi) begin hb = b; have_hi = 1; end
        else begin fr.push_back({hb, b}); have_hi = 0; end
      end
    end
    addr = 12'o0200;
    sum  = 12'd0;
    for (int k = 0; k < fr.size(); k++) begin
      h = fr[k][15:8];
      l = fr[k][7:0];
      v = {h[5:0], l[5:0]};
      if (h[6]) begin
        addr = v;
      end else if (k < fr.size() - 1) begin
        // a data word is committed once any later frame arrives
        exp_q.push_back({addr, v});
        addr = addr + 12'd1;
        exp_wc++;
      end else if (by_trailer) begin
        exp_ck = (v == sum);
      end
      sum = sum + 12'(h) + 12'(l);
    end
    exp_done = by_trailer;
    exp_err  = by_error;
  endtask

  task automatic maybe_field(inout tape_t t);
    if ($urandom_range(0, 5) == 0) t.push_back(8'o300 | byte_t'($urandom_range(0, 63)));
  endtask

  task automatic gen_tape(output tape_t t);
    int          nfr, mode;
    logic [11:0] v, gsum;
    byte_t       h, l;
    t.delete();
    gsum = 12'd0;
    repeat ($urandom_range(0, 3)) begin
      h = byte_t'($urandom_range(0, 255));
      if (h == 8'o200) h = 8'o017;
      t.push_back(h);
    end
    repeat ($urandom_range(1, 3)) t.push_back(8'o200);
    nfr = int'($urandom_range(1, 6));
    for (int k = 0; k < nfr; k++) begin
      v = 12'($urandom);
      h = ($urandom_range(0, 4) == 0) ? {2'b01, v[11:6]} : {2'b00, v[11:6]};
      l = {1'b0, 1'($urandom_range(0, 1)), v[5:0]};
      t.push_back(h); maybe_field(t);
      t.push_back(l); maybe_field(t);
      gsum = gsum + 12'(h) + 12'(l);
    end
    mode = int'($urandom_range(0, 7));
    if (mode == 0) begin
      t.push_back(8'o012);
      t.push_back(8'o200);
    end else if (mode != 1) begin
      v = (mode == 2) ? (gsum ^ 12'(1 << $urandom_range(0, 11))) : gsum;
      t.push_back({2'b00, v[11:6]});
      t.push_back({2'b00, v[5:0]});
    end
    t.push_back(8'o200);
    t.push_back(8'o200);
  endtask

  // Memory responder
  initial begin : resp
    int dly;
    dly = pick_delay();
    forever begin
      @(negedge clk);
      if (!btnCpuReset) begin
        mem_finished = 1'b0;
        dly = pick_delay();
      end else if (mem_finished) begin
        mem_finished = 1'b0;
      end else if (mem_write_enable) begin
        if (dly <= 0) begin
          mem_finished = 1'b1;
          dly = pick_delay();
        end else begin
          dly--;
        end
      end
    end
  end

  // Per-cycle compare process
  initial begin : mon
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_req = 1'b0;
      end else begin
        check("ready_during_write", byte_ready & mem_write_enable, 0);
        check("done_with_error", done & error, 0);
        check("ok_without_done", checksum_ok & ~done, 0);
        if (mem_write_enable) begin
          if (!in_req) begin
            in_req = 1'b1;
            req_addr = mem_address;
            req_data = mem_write_data;
            if (exp_q.size() == 0) begin
              fail_now($sformatf("unexpected_write: got %04o<-%04o, required no write", mem_address, mem_write_data));
            end else begin
              e = exp_q.pop_front();
              check("write_addr", mem_address, e[23:12]);
              check("write_data", mem_write_data, e[11:0]);
            end
          end else begin
            check("addr_stable", mem_address, req_addr);
            check("data_stable", mem_write_data, req_data);
          end
        end else begin
          in_req = 1'b0;
        end
      end
    end
  end

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_in_seek", byte_ready, 1);
    check("done_cleared", done | error, 0);
  endtask

  task automatic run_tape(input tape_t t, input bit stop_on_write);
    int idx, guard;
    idx = 0; guard = 0;
    while (idx < t.size() && guard < 3000) begin
      @(negedge clk);
      guard++;
      start = 1'b0;
      if (stop_on_write && mem_write_enable) begin
        byte_valid = 1'b0;
        return;
      end
      if (!busy) break;
      if ($urandom_range(0, 15) == 0) start = 1'b1;  // must be ignored while busy
      if ($urandom_range(0, 3) == 0) begin
        byte_valid = 1'b0;
      end else begin
        byte_valid = 1'b1;
        byte_data  = t[idx];
        if (byte_ready) idx++;
      end
    end
    @(negedge clk);
    byte_valid = 1'b0;
    start = 1'b0;
    guard = 0;
    while (busy && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (busy) fail_now($sformatf("tape_timeout: busy=1 after %0d cycles, required 0", guard));
  endtask

  task automatic check_final(input string tag);
    check({tag, "_done"}, done, exp_done);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_checksum_ok"}, checksum_ok, exp_ck & exp_done);
    check({tag, "_word_count"}, word_count, exp_wc);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic run_case(input tape_t t, input string tag);
    model_tape(t);
    do_start();
    run_tape(t, 1'b0);
    check_final(tag);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, byte_ready, 0);
    check({tag, "_we"}, mem_write_enable, 0);
    check({tag, "_addr"}, mem_address, 0);
    check({tag, "_wdata"}, mem_write_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flags"}, {done, checksum_ok, error}, 0);
    check({tag, "_count"}, word_count, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : main
    tape_t t;
    byte_t a1[10] = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o074, 8'o001, 8'o001, 8'o077, 8'o200, 8'o200};
    byte_t a2[10] = '{8'o200, 8'o200, 8'o102, 8'o000, 8'o074, 8'o001, 8'o001, 8'o076, 8'o200, 8'o200};
    byte_t a3[3]  = '{8'o200, 8'o102, 8'o200};
    byte_t a4[12] = '{8'o200, 8'o177, 8'o077, 8'o012, 8'o034, 8'o056, 8'o070, 8'o005, 8'o012, 8'o200, 8'o200, 8'o200};
    byte_t a6[14] = '{8'o017, 8'o300, 8'o200, 8'o200, 8'o102, 8'o000, 8'o310, 8'o074, 8'o001, 8'o310,
                      8'o001, 8'o077, 8'o200, 8'o200};

    btnCpuReset = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    btnCpuReset = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    check_all_zero("idle");

    // T1 normal load
    t.delete(); foreach (a1[i]) t.push_back(a1[i]);
    model_tape(t);
    check("model_T1_nwrites", exp_q.size(), 1);
    check("model_T1_write", exp_q[0], {12'o0200, 12'o7401});
    check("model_T1_ok", exp_ck, 1);
    do_start(); run_tape(t, 1'b0); check_final("T1");
    check("T1_done_lit", done, 1);
    check("T1_ok_lit", checksum_ok, 1);
    check("T1_count_lit", word_count, 1);

    // T2 bad checksum
    t.delete(); foreach (a2[i]) t.push_back(a2[i]);
    model_tape(t);
    check("model_T2_write", exp_q[0], {12'o0200, 12'o7401});
    check("model_T2_ok", exp_ck, 0);
    do_start(); run_tape(t, 1'b0); check_final("T2");
    check("T2_ok_lit", {done, checksum_ok}, 2'b10);

    // T3 framing error
    t.delete(); foreach (a3[i]) t.push_back(a3[i]);
    model_tape(t);
    check("model_T3_err", {exp_err, exp_done}, 2'b10);
    check("model_T3_nwrites", exp_q.size(), 0);
    do_start(); run_tape(t, 1'b0); check_final("T3");
    byte_valid = 1'b1;
    byte_data  = 8'o200;
    repeat (4) begin
      @(negedge clk);
      check("T3_ready_after_error", byte_ready, 0);
      check("T3_error_held", error, 1);
    end
    byte_valid = 1'b0;

    // T4 slow memory and address wrap
    mem_delay_fixed = 5;
    t.delete(); foreach (a4[i]) t.push_back(a4[i]);
    model_tape(t);
    check("model_T4_write0", exp_q[0], {12'o7777, 12'o1234});
    check("model_T4_write1", exp_q[1], {12'o0000, 12'o5670});
    check("model_T4_ok", exp_ck, 1);
    do_start(); run_tape(t, 1'b0); check_final("T4");
    check("T4_count_lit", word_count, 2);
    mem_delay_fixed = -1;

    // T6 field bytes and pre-leader garbage
    t.delete(); foreach (a6[i]) t.push_back(a6[i]);
    model_tape(t);
    check("model_T6_write", exp_q[0], {12'o0200, 12'o7401});
    check("model_T6_ok", {exp_ck, exp_wc}, {1'b1, 13'd1});
    do_start(); run_tape(t, 1'b0); check_final("T6");
    check("T6_ok_lit", checksum_ok, 1);

    // T5 reset in the middle of a write
    mem_delay_fixed = 8;
    t.delete(); foreach (a1[i]) t.push_back(a1[i]);
    model_tape(t);
    do_start();
    run_tape(t, 1'b1);
    check("T5_we_before_reset", mem_write_enable, 1);
    #2;
    mon_en = 1'b0;
    btnCpuReset = 1'b0;
    #1;
    check_all_zero("T5_async");
    exp_q.delete();
    @(negedge clk);
    check_all_zero("T5_held");
    btnCpuReset = 1'b1;
    mon_en = 1'b1;
    mem_delay_fixed = -1;
    run_case(t, "T5_reload");
    check("T5_ok_lit", {done, checksum_ok, word_count}, {2'b11, 13'd1});

    // Randomized tapes
    for (int n = 0; n < 40; n++) begin
      gen_tape(t);
      run_case(t, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
